// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over GATE_PERIOD clk_int cycles.
// Define FREQ_METER_BCD_EN to add a sequential double-dabble converter that drives bcd.
module freq_meter #(
  parameter int GATE_PERIOD = 12_000_000,
  parameter int CNT_W       = 24,
  parameter int BCD_DIGITS  = 8
) (
  input  logic                    clk_int,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sig_in,
  output logic [CNT_W-1:0]        freq,
  output logic                    ovf,
  output logic                    valid,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int                GATE_W    = $clog2(GATE_PERIOD);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic              s1, s2, s3;
  logic              edge_det;
  logic [GATE_W-1:0] gate_cnt;
  logic              terminal;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sticky_ovf;
  logic              at_max;
  logic [CNT_W-1:0]  cap_val;
  logic              cap_ovf;

  // Synchronizer is cleared while disabled so a level already high is seen as a fresh edge.
  always_ff @(posedge clk_int) begin
    if (!rst || !en) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;
  assign terminal = en && (gate_cnt == GATE_LAST);
  assign at_max   = (edge_cnt == CNT_MAX);
  assign cap_val  = (edge_det && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
  assign cap_ovf  = sticky_ovf | (edge_det & at_max);

  always_ff @(posedge clk_int) begin
    if (!rst || !en) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sticky_ovf <= 1'b0;
    end else if (terminal) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sticky_ovf <= 1'b0;
    end else begin
      gate_cnt   <= gate_cnt + 1'b1;
      edge_cnt   <= cap_val;
      sticky_ovf <= cap_ovf;
    end
  end

  // valid is a one-cycle strobe with no back-pressure; freq/ovf/bcd stay stable until the next strobe.
`ifdef FREQ_METER_BCD_EN
  localparam int               BCD_W      = 4 * BCD_DIGITS;
  localparam int               BIT_W      = $clog2(CNT_W + 1);
  localparam logic [BIT_W-1:0] LAST_SHIFT = BIT_W'(CNT_W - 1);

  typedef enum logic {IDLE, CONV} conv_state_t;

  conv_state_t      state;
  logic [BCD_W-1:0] bcd_sh, bcd_adj, bcd_nxt;
  logic [CNT_W-1:0] bin_sh, bin_nxt;
  logic [BIT_W-1:0] shift_cnt;
  logic [CNT_W-1:0] hold_val;
  logic             hold_ovf;

  always_comb begin
    bcd_adj = bcd_sh;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_sh[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj, bin_sh} << 1;
  end

  always_ff @(posedge clk_int) begin
    if (!rst) begin
      state     <= IDLE;
      bcd_sh    <= '0;
      bin_sh    <= '0;
      shift_cnt <= '0;
      hold_val  <= '0;
      hold_ovf  <= 1'b0;
      freq      <= '0;
      ovf       <= 1'b0;
      valid     <= 1'b0;
      bcd       <= '0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else if (terminal) begin
        state     <= CONV;
        bcd_sh    <= '0;
        bin_sh    <= cap_val;
        shift_cnt <= '0;
        hold_val  <= cap_val;
        hold_ovf  <= cap_ovf;
      end else if (state == CONV) begin
        bcd_sh    <= bcd_nxt;
        bin_sh    <= bin_nxt;
        shift_cnt <= shift_cnt + 1'b1;
        if (shift_cnt == LAST_SHIFT) begin
          state <= IDLE;
          freq  <= hold_val;
          ovf   <= hold_ovf;
          bcd   <= bcd_nxt;
          valid <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk_int) begin
    if (!rst) begin
      freq  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= terminal;
      if (terminal) begin
        freq <= cap_val;
        ovf  <= cap_ovf;
      end
    end
  end

  assign bcd = '0;
`endif

endmodule
